// File: rtl/alu_multicycle_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_multicycle_pkg : micro-op codes, flag type and FSM states         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package alu_multicycle_pkg;

  localparam logic [4:0] c_NOP = 5'd0;
  localparam logic [4:0] c_ADD = 5'd1;
  localparam logic [4:0] c_SUB = 5'd2;
  localparam logic [4:0] c_CMP = 5'd3;
  localparam logic [4:0] c_AND = 5'd4;
  localparam logic [4:0] c_EOR = 5'd5;
  localparam logic [4:0] c_LSL = 5'd6;
  localparam logic [4:0] c_LSR = 5'd7;
  localparam logic [4:0] c_MOV = 5'd8;
  localparam logic [4:0] c_STR = 5'd9;
  localparam logic [4:0] c_LDR = 5'd10;
  localparam logic [4:0] c_ADC = 5'd11;
  localparam logic [4:0] c_SBC = 5'd12;
  localparam logic [4:0] c_ASR = 5'd13;
  localparam logic [4:0] c_MUL = 5'd14;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    MUL_RUN = 2'd2
  } alu_state_t;

  // Ops that produce an output beat on the edge they are accepted.
  function automatic logic is_single_cycle(input logic [4:0] uop);
    logic r;
    case (uop)
      c_ADD, c_SUB, c_CMP, c_AND, c_EOR, c_LSL, c_LSR, c_MOV,
      c_STR, c_LDR, c_ADC, c_SBC, c_ASR: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_multicycle_mul.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_mul_iter : iterative shift-add multiplier, one partial per cycle  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_cnt    <= CNT_W'(WIDTH);
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_cnt != '0) begin
      r_cnt    <= r_cnt - 1'b1;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_acc_next;
    end
  end

  // The final partial sum is handed out combinationally on the edge the counter hits 0.
  assign o_done    = (r_cnt == CNT_W'(1));
  assign o_product = w_acc_next;

endmodule
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_multicycle : registered ALU with NZCV flags and iterative MUL     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  input  logic [4:0]       uop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_alu,
  output logic [3:0]       flags_out,
  output logic             busy
);

  alu_state_t       r_state;
  alu_state_t       w_state_next;
  flags_t           r_flags;
  flags_t           w_flags_calc;
  flags_t           w_flags_mul;
  logic [WIDTH-1:0] r_out_alu;
  logic [WIDTH-1:0] w_res;
  logic             w_ready;
  logic             w_load_single;
  logic             w_load_mul;
  logic             w_mul_start;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;
  logic             w_is_mul;
  logic             w_is_single;

  logic [SHAMT_W-1:0] w_amt;
  logic               w_cin;
  logic               w_bin;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_lsl;
  logic [WIDTH:0]     w_lsr;
  logic [WIDTH:0]     w_asr;

  assign w_is_mul    = (uop == c_MUL);
  assign w_is_single = is_single_cycle(uop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_ready       = 1'b0;
    w_load_single = 1'b0;
    w_load_mul    = 1'b0;
    w_mul_start   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (in_valid && w_is_mul) begin
          w_state_next = MUL_RUN;
          w_mul_start  = 1'b1;
        end else if (in_valid && w_is_single) begin
          w_state_next  = HOLD;
          w_load_single = 1'b1;
        end
      end
      HOLD: begin
        w_ready = out_ready;
        if (out_ready) begin
          w_state_next = IDLE;
          if (in_valid && w_is_mul) begin
            w_state_next = MUL_RUN;
            w_mul_start  = 1'b1;
          end else if (in_valid && w_is_single) begin
            w_state_next  = HOLD;
            w_load_single = 1'b1;
          end
        end
      end
      MUL_RUN: begin
        if (w_mul_done) begin
          w_state_next = HOLD;
          w_load_mul   = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign in_ready = w_ready & ~reset;

  // Carry-in comes from the flag register, which always belongs to the latest produced result.
  assign w_amt  = rhs[SHAMT_W-1:0];
  assign w_cin  = (uop == c_ADC) & r_flags.c;
  assign w_bin  = (uop == c_SBC) & ~r_flags.c;
  assign w_sum  = {1'b0, lhs} + {1'b0, rhs} + {{WIDTH{1'b0}}, w_cin};
  assign w_diff = {1'b0, lhs} - {1'b0, rhs} - {{WIDTH{1'b0}}, w_bin};
  assign w_lsl  = {1'b0, lhs} << w_amt;
  assign w_lsr  = {lhs, 1'b0} >> w_amt;
  assign w_asr  = $signed({lhs, 1'b0}) >>> w_amt;

  always_comb begin
    w_res        = '0;
    w_flags_calc = r_flags;
    case (uop)
      c_ADD, c_ADC: begin
        w_res          = w_sum[WIDTH-1:0];
        w_flags_calc.c = w_sum[WIDTH];
        w_flags_calc.v = (lhs[WIDTH-1] == rhs[WIDTH-1]) && (w_res[WIDTH-1] != lhs[WIDTH-1]);
      end
      c_SUB, c_SBC, c_CMP: begin
        w_res          = w_diff[WIDTH-1:0];
        w_flags_calc.c = ~w_diff[WIDTH];
        w_flags_calc.v = (lhs[WIDTH-1] != rhs[WIDTH-1]) && (w_res[WIDTH-1] != lhs[WIDTH-1]);
      end
      c_AND, c_EOR, c_MOV: begin
        w_res          = (uop == c_AND) ? (lhs & rhs) : (uop == c_EOR) ? (lhs ^ rhs) : rhs;
        w_flags_calc.c = 1'b0;
        w_flags_calc.v = 1'b0;
      end
      c_LSL: begin
        w_res = w_lsl[WIDTH-1:0];
        if (w_amt != '0) w_flags_calc.c = w_lsl[WIDTH];
      end
      c_LSR: begin
        w_res = w_lsr[WIDTH:1];
        if (w_amt != '0) w_flags_calc.c = w_lsr[0];
      end
      c_ASR: begin
        w_res = w_asr[WIDTH:1];
        if (w_amt != '0) w_flags_calc.c = w_asr[0];
      end
      c_STR, c_LDR: w_res = lhs + rhs;
      default: w_res = '0;
    endcase
    if (uop != c_STR && uop != c_LDR) begin
      w_flags_calc.n = w_res[WIDTH-1];
      w_flags_calc.z = (w_res == '0);
    end
  end

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst       (reset),
    .i_start   (w_mul_start),
    .i_a       (lhs),
    .i_b       (rhs),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  always_comb begin
    w_flags_mul   = r_flags;
    w_flags_mul.n = w_mul_product[WIDTH-1];
    w_flags_mul.z = (w_mul_product == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_alu <= '0;
      r_flags   <= '0;
    end else if (w_load_single) begin
      r_out_alu <= w_res;
      r_flags   <= w_flags_calc;
    end else if (w_load_mul) begin
      r_out_alu <= w_mul_product;
      r_flags   <= w_flags_mul;
    end
  end

  assign out_valid = (r_state == HOLD);
  assign busy      = (r_state == MUL_RUN);
  assign out_alu   = r_out_alu;
  assign flags_out = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_alu_multicycle : random + directed bench with a behavioural model  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_alu_multicycle;
  import alu_multicycle_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] lhs = '0;
  logic [W-1:0] rhs = '0;
  logic [4:0]   uop = c_NOP;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_alu;
  logic [3:0]   flags_out;
  logic         busy;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W), .SHAMT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lhs       (lhs),
    .rhs       (rhs),
    .uop       (uop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_alu   (out_alu),
    .flags_out (flags_out),
    .busy      (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   nzcv;
    int           due;
    bit           mul;
  } exp_t;

  exp_t       q[$];
  logic [3:0] m_flags    = '0;
  logic [3:0] last_flags = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Architectural meaning of every op, using wide integer arithmetic and bitwise shifting loops.
  function automatic void model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [3:0] fin, output logic [W-1:0] r,
                                output logic [3:0] fo, output bit beat, output bit mul);
    longint unsigned ua, ub, u;
    longint          sa, sb, s;
    logic            n, z, c, v, setnz, k;
    int              amt;
    ua = 64'(a); ub = 64'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    {n, z, c, v} = fin;
    r = '0; beat = 1; mul = 0; setnz = 1;
    case (op)
      c_ADD, c_ADC: begin
        k = (op == c_ADC) ? c : 1'b0;
        u = ua + ub + 64'(k);
        r = u[W-1:0];
        c = (u >= 64'h1_0000_0000);
        s = sa + sb + longint'(k);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      c_SUB, c_SBC, c_CMP: begin
        k = (op == c_SBC) ? !c : 1'b0;
        r = a - b - W'(k);
        c = (ua >= ub + 64'(k));
        s = sa - sb - longint'(k);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      c_AND: begin r = a & b; c = 0; v = 0; end
      c_EOR: begin r = a ^ b; c = 0; v = 0; end
      c_MOV: begin r = b;     c = 0; v = 0; end
      c_LSL, c_LSR, c_ASR: begin
        amt = int'(b[7:0]);
        r = a;
        for (int i = 0; i < amt; i++) begin
          if (op == c_LSL) begin c = r[W-1]; r = r << 1; end
          else if (op == c_LSR) begin c = r[0]; r = r >> 1; end
          else begin c = r[0]; r = {r[W-1], r[W-1:1]}; end
        end
      end
      c_MUL: begin r = a * b; mul = 1; end
      c_STR, c_LDR: begin r = a + b; setnz = 0; end
      default: begin beat = 0; setnz = 0; end
    endcase
    if (setnz) begin n = r[W-1]; z = (r == '0); end
    fo = {n, z, c, v};
  endfunction

  // Per-cycle compare against the model: handshake, busy, ordering, data and flags.
  always @(negedge clk) begin : mon
    bit           ev, eb, er, beat, mul;
    exp_t         e;
    logic [W-1:0] r;
    logic [3:0]   f;
    cyc++;
    if (reset) begin
      q.delete();
      m_flags    = '0;
      last_flags = '0;
    end else begin
      ev = 0; eb = 0;
      if (q.size() > 0) begin
        ev = (cyc >= q[0].due);
        eb = q[0].mul && (cyc < q[0].due);
      end
      er = !eb && (!ev || out_ready);
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("busy",      64'(busy),      64'(eb));
      chk("in_ready",  64'(in_ready),  64'(er));
      if (ev) begin
        chk("out_alu",   64'(out_alu),   64'(q[0].res));
        chk("flags_out", 64'(flags_out), 64'(q[0].nzcv));
        if (out_ready) begin
          e = q.pop_front();
          last_flags = e.nzcv;
        end
      end else begin
        chk("flags_idle", 64'(flags_out), 64'(last_flags));
      end
      if (in_valid && er) begin
        model(uop, lhs, rhs, m_flags, r, f, beat, mul);
        m_flags = f;
        if (beat) q.push_back('{r, f, cyc + (mul ? W + 1 : 1), mul});
      end
    end
  end

  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic [3:0] ef, input int elat);
    int t;
    @(posedge clk); #1;
    in_valid = 1; uop = op; lhs = a; rhs = b; out_ready = 1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++t > 100) begin chk("accept_timeout", 64'd1, 64'd0); break; end
    end
    @(posedge clk); #1;
    in_valid = 0;
    t = 0;
    forever begin
      @(negedge clk);
      t++;
      if (out_valid) break;
      if (t > 100) begin chk("result_timeout", 64'd1, 64'd0); break; end
    end
    chk("lit_res",  64'(out_alu),   64'(er));
    chk("lit_nzcv", 64'(flags_out), 64'(ef));
    chk("lit_lat",  64'(t),         64'(elat));
  endtask

  function automatic logic [W-1:0] rnd_word();
    case ($urandom % 6)
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  logic [4:0] ops [15] = '{c_NOP, c_ADD, c_SUB, c_CMP, c_AND, c_EOR, c_LSL, c_LSR,
                           c_MOV, c_STR, c_LDR, c_ADC, c_SBC, c_ASR, c_MUL};

  initial begin
    // Offer an op while reset is held: nothing may be accepted.
    in_valid = 1; uop = c_ADD; lhs = 32'd1; rhs = 32'd2; out_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_alu",   64'(out_alu),   64'd0);
    chk("rst_flags",     64'(flags_out), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    @(posedge clk); #1;
    in_valid = 0; reset = 0;

    run_op(c_ADD, 32'h7FFF_FFFF, 32'd1,  32'h8000_0000, 4'b1001, 1);
    run_op(c_SUB, 32'd3,  32'd5,         32'hFFFF_FFFE, 4'b1000, 1);
    run_op(c_SUB, 32'd5,  32'd5,         32'h0,         4'b0110, 1);
    run_op(c_SBC, 32'd10, 32'd3,         32'd7,         4'b0010, 1);
    run_op(c_ADC, 32'hFFFF_FFFF, 32'd0,  32'h0,         4'b0110, 1);
    run_op(c_LSL, 32'h8000_0001, 32'd1,  32'h2,         4'b0010, 1);
    run_op(c_ASR, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 4'b1010, 1);
    run_op(c_LSR, 32'h1234_5678, 32'h100, 32'h1234_5678, 4'b0010, 1);
    run_op(c_STR, 32'h1000, 32'h24,      32'h1024,      4'b0010, 1);
    run_op(c_MUL, 32'd1234, 32'd5678,    32'd7006652,   4'b0010, W + 1);
    run_op(c_EOR, 32'hFF, 32'hFF,        32'h0,         4'b0100, 1);
    run_op(c_MUL, 32'd3, 32'd4,          32'd12,        4'b0000, W + 1);
    run_op(c_SUB, 32'd3, 32'd5,          32'hFFFF_FFFE, 4'b1000, 1);

    // Reset during a multiply discards it and clears the flags at once.
    @(posedge clk); #1;
    in_valid = 1; uop = c_MUL; lhs = 32'd7; rhs = 32'd9;
    @(negedge clk);
    chk("mul_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 0;
    repeat (9) @(posedge clk);
    #3 reset = 1;
    #1;
    chk("midmul_out_valid", 64'(out_valid), 64'd0);
    chk("midmul_busy",      64'(busy),      64'd0);
    chk("midmul_flags",     64'(flags_out), 64'd0);
    chk("midmul_out_alu",   64'(out_alu),   64'd0);
    @(posedge clk); #1;
    reset = 0;
    repeat (W + 4) @(posedge clk);

    // Burst of 8 ADDs under random output back-pressure.
    for (int i = 0; i < 8; i++) begin
      int t;
      #1;
      in_valid = 1; uop = c_ADD; lhs = rnd_word(); rhs = rnd_word();
      t = 0;
      forever begin
        out_ready = ($urandom % 2) == 0;
        @(negedge clk);
        if (in_ready) break;
        if (++t > 100) begin chk("burst_timeout", 64'd1, 64'd0); break; end
        @(posedge clk); #1;
      end
      @(posedge clk);
    end
    #1 in_valid = 0; out_ready = 1;
    repeat (4) @(posedge clk);

    // Random mix of every op, unknown codes and back-pressure.
    for (int i = 0; i < 2500; i++) begin
      #1;
      in_valid  = ($urandom % 4) != 0;
      uop       = (($urandom % 10) == 0) ? 5'($urandom) : ops[$urandom % 15];
      lhs       = rnd_word();
      rhs       = (($urandom % 2) == 0) ? W'($urandom_range(0, 40)) : rnd_word();
      out_ready = ($urandom % 3) != 0;
      @(posedge clk);
    end
    #1 in_valid = 0; out_ready = 1;
    repeat (W + 4) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
